// File: rtl/fpa_add_pkg.sv
// Shared types and helpers for the pipelined chunked adder: chunk-count
// function, propagate/generate pair type and the group combine operator.
package fpa_add_pkg;

   localparam int DEFAULT_WIDTH   = 32;
   localparam int DEFAULT_CHUNK_W = 8;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   // Chunk width is clamped to [1, width] so that illegal configurations
   // still elaborate far enough to report their own error.
   function automatic int num_chunks(input int width, input int chunk_w);
      int w;
      int cw;
      w  = (width < 1) ? 1 : width;
      cw = (chunk_w < 1) ? 1 : chunk_w;
      if (cw > w) cw = w;
      return (w + cw - 1) / cw;
   endfunction

   function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
      pg_t r;
      r.p = hi.p & lo.p;
      r.g = hi.g | (hi.p & lo.g);
      return r;
   endfunction

endpackage

// File: rtl/fpa_chunk_add.sv
// Combinational W-bit ripple adder built from per-bit propagate/generate
// cells; also reports the carry into its MSB and the group p/g pair.
module fpa_chunk_add
   import fpa_add_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         ci_i,
   output logic [W-1:0] sum_o,
   output logic         co_o,
   output logic         cmsb_o,
   output pg_t          pg_o
);

   logic [W:0] cy;
   pg_t        grp;

   // Propagate is a|b rather than a^b so that co = G | P&ci holds for the
   // group pair exported to the next stage.
   always_comb begin
      cy    = '0;
      cy[0] = ci_i;
      sum_o = '0;
      grp   = '{p: 1'b1, g: 1'b0};
      for (int i = 0; i < W; i++) begin
         sum_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
         cy[i+1]   = (a_i[i] & b_i[i]) | ((a_i[i] | b_i[i]) & cy[i]);
         grp       = pg_combine('{p: a_i[i] | b_i[i], g: a_i[i] & b_i[i]}, grp);
      end
   end

   assign co_o   = cy[W];
   assign cmsb_o = cy[W-1];
   assign pg_o   = grp;

endmodule

// File: rtl/pipelined_chunk_add.sv
// Pipelined fixed-point adder resolving one CHUNK_W-bit chunk per stage with
// valid/ready streaming. Define FPA_ADD_SUBTRACT_EN to add the sub port.
module pipelined_chunk_add
   import fpa_add_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int CHUNK_W = DEFAULT_CHUNK_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef FPA_ADD_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             co,
   output logic             ovf,
   output logic             cp,
   output logic             cg
);

   localparam int CW         = (CHUNK_W < 1) ? 1 : ((CHUNK_W > WIDTH) ? WIDTH : CHUNK_W);
   localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK_W);

   if (WIDTH < 1 || CHUNK_W < 1) begin : g_bad_cfg
      $error("pipelined_chunk_add: WIDTH and CHUNK_W must both be >= 1");
   end

   // Handshake: a beat moves whenever adv is high. The whole pipeline shares
   // one advance so a stalled output freezes every stage and holds in_ready low.
   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             ci_eff;

`ifdef FPA_ADD_SUBTRACT_EN
   assign b_eff  = sub ? ~b : b;
   assign ci_eff = sub | ci;
`else
   assign b_eff  = b;
   assign ci_eff = ci;
`endif

   for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_stg
      localparam int LO = k * CW;
      localparam int HI = (LO + CW > WIDTH) ? WIDTH : LO + CW;

      logic [WIDTH-1:LO] src_a;
      logic [WIDTH-1:LO] src_b;
      logic              vld_d, vld_q;
      logic              cy_in;
      logic              cy_d, cy_q;
      logic [HI-LO-1:0]  sum;
      logic              cout;
      logic              cmsb;
      pg_t               cpg;
      pg_t               pg_d, pg_q;
      logic [HI-1:0]     res_d, res_q;

      if (k == 0) begin : g_head
         assign src_a = a;
         assign src_b = b_eff;
         assign vld_d = in_valid;
         assign cy_in = ci_eff;
         assign res_d = sum;
         assign pg_d  = cpg;
      end else begin : g_body
         assign src_a = g_stg[k-1].g_ops.opa_q;
         assign src_b = g_stg[k-1].g_ops.opb_q;
         assign vld_d = g_stg[k-1].vld_q;
         assign cy_in = g_stg[k-1].cy_q;
         assign res_d = {sum, g_stg[k-1].res_q};
         assign pg_d  = pg_combine(cpg, g_stg[k-1].pg_q);
      end

      fpa_chunk_add #(
         .W (HI - LO)
      ) u_chunk (
         .a_i    (src_a[HI-1:LO]),
         .b_i    (src_b[HI-1:LO]),
         .ci_i   (cy_in),
         .sum_o  (sum),
         .co_o   (cout),
         .cmsb_o (cmsb),
         .pg_o   (cpg)
      );

      assign cy_d = cout;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            res_q <= '0;
            pg_q  <= '0;
         end else if (adv) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            res_q <= res_d;
            pg_q  <= pg_d;
         end
      end

      // Operand bits not yet summed ride along, skewed one chunk per stage.
      if (k < NUM_CHUNKS - 1) begin : g_ops
         logic [WIDTH-1:HI] opa_d, opa_q;
         logic [WIDTH-1:HI] opb_d, opb_q;
         logic              unused_cmsb;

         assign unused_cmsb = cmsb;
         assign opa_d       = src_a[WIDTH-1:HI];
         assign opb_d       = src_b[WIDTH-1:HI];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               opa_q <= '0;
               opb_q <= '0;
            end else if (adv) begin
               opa_q <= opa_d;
               opb_q <= opb_d;
            end
         end
      end else begin : g_tail
         logic ovf_d, ovf_q;

         assign ovf_d = cmsb ^ cout;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign out_valid = g_stg[NUM_CHUNKS-1].vld_q;
   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;
   assign c         = g_stg[NUM_CHUNKS-1].res_q;
   assign co        = g_stg[NUM_CHUNKS-1].cy_q;
   assign ovf       = g_stg[NUM_CHUNKS-1].g_tail.ovf_q;
   assign cp        = g_stg[NUM_CHUNKS-1].pg_q.p;
   assign cg        = g_stg[NUM_CHUNKS-1].pg_q.g;

endmodule

// File: tb/tb_pipelined_chunk_add.sv
// Bench for pipelined_chunk_add: a 32/8 instance and a 13/4 instance share
// the stream; an arithmetic model plus literal vectors check both.
module tb_pipelined_chunk_add;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        ci;
   logic        sub_v;

   logic        in_ready1, out_valid1, co1, ovf1, cp1, cg1;
   logic [31:0] c1;
   logic        in_ready2, out_valid2, co2, ovf2, cp2, cg2;
   logic [12:0] c2;

   int checks = 0;
   int errors = 0;
   int ret1   = 0;
   logic acc_seen = 1'b0;

   logic [67:0] exp_q1[$];
   logic [67:0] exp_q2[$];

   pipelined_chunk_add #(.WIDTH(32), .CHUNK_W(8)) u_dut32 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .a         (a),
      .b         (b),
      .ci        (ci),
`ifdef FPA_ADD_SUBTRACT_EN
      .sub       (sub_v),
`endif
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .c         (c1),
      .co        (co1),
      .ovf       (ovf1),
      .cp        (cp1),
      .cg        (cg1)
   );

   pipelined_chunk_add #(.WIDTH(13), .CHUNK_W(4)) u_dut13 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .a         (a[12:0]),
      .b         (b[12:0]),
      .ci        (ci),
`ifdef FPA_ADD_SUBTRACT_EN
      .sub       (sub_v),
`endif
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .c         (c2),
      .co        (co2),
      .ovf       (ovf2),
      .cp        (cp2),
      .cg        (cg2)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   // ---------------- model ----------------
   // Result packed as {cg, cp, ovf, co, c[63:0]} for a w-bit adder.
   function automatic logic [67:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                         input logic civ, input logic subv);
      logic [63:0] mask, aa, bb, cc;
      logic [64:0] full, gen;
      logic        cin, co_m, ovf_m, cp_m, cg_m;
      mask  = (64'd1 << w) - 64'd1;
      aa    = av & mask;
      bb    = (subv ? ~bv : bv) & mask;
      cin   = subv ? 1'b1 : civ;
      full  = {1'b0, aa} + {1'b0, bb} + {64'd0, cin};
      gen   = {1'b0, aa} + {1'b0, bb};
      cc    = full[63:0] & mask;
      co_m  = full[w];
      ovf_m = (aa[w-1] == bb[w-1]) && (cc[w-1] != aa[w-1]);
      cp_m  = ((aa | bb) & mask) == mask;
      cg_m  = gen[w];
      return {cg_m, cp_m, ovf_m, co_m, cc};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // ---------------- scoreboard / compare process ----------------
   initial begin
      logic [67:0] e;
      logic [67:0] g;
      logic        hold1, hold2;
      logic [31:0] hc1;
      logic [12:0] hc2;
      logic        hco1, hco2;
      hold1 = 1'b0; hold2 = 1'b0;
      hc1 = '0; hc2 = '0; hco1 = 1'b0; hco2 = 1'b0;
      forever begin
         @(negedge clk);
         acc_seen = 1'b0;
         if (rst) begin
            hold1 = 1'b0;
            hold2 = 1'b0;
         end else begin
            if (in_valid && in_ready1) begin
               exp_q1.push_back(model(32, {32'd0, a}, {32'd0, b}, ci, sub_v));
               acc_seen = 1'b1;
            end
            if (in_valid && in_ready2)
               exp_q2.push_back(model(13, {32'd0, a}, {32'd0, b}, ci, sub_v));
            if (hold1) begin
               checks++;
               if (!out_valid1 || c1 !== hc1 || co1 !== hco1) begin
                  errors++;
                  $display("FAIL w32_hold: got v=%0b c=%h co=%0b required v=1 c=%h co=%0b",
                           out_valid1, c1, co1, hc1, hco1);
               end
            end
            if (hold2) begin
               checks++;
               if (!out_valid2 || c2 !== hc2 || co2 !== hco2) begin
                  errors++;
                  $display("FAIL w13_hold: got v=%0b c=%h co=%0b required v=1 c=%h co=%0b",
                           out_valid2, c2, co2, hc2, hco2);
               end
            end
            if (out_valid1 && out_ready) begin
               ret1++;
               checks++;
               if (exp_q1.size() == 0) begin
                  errors++;
                  $display("FAIL w32_unexpected: got result c=%h required no output", c1);
               end else begin
                  e = exp_q1.pop_front();
                  g = {cg1, cp1, ovf1, co1, 32'd0, c1};
                  if (g !== e) begin
                     errors++;
                     $display("FAIL w32_result: got cg/cp/ovf/co=%b c=%h required %b c=%h",
                              g[67:64], g[31:0], e[67:64], e[31:0]);
                  end
               end
            end
            if (out_valid2 && out_ready) begin
               checks++;
               if (exp_q2.size() == 0) begin
                  errors++;
                  $display("FAIL w13_unexpected: got result c=%h required no output", c2);
               end else begin
                  e = exp_q2.pop_front();
                  g = {cg2, cp2, ovf2, co2, 51'd0, c2};
                  if (g !== e) begin
                     errors++;
                     $display("FAIL w13_result: got cg/cp/ovf/co=%b c=%h required %b c=%h",
                              g[67:64], g[12:0], e[67:64], e[12:0]);
                  end
               end
            end
            hold1 = out_valid1 && !out_ready;
            hold2 = out_valid2 && !out_ready;
            hc1 = c1; hco1 = co1;
            hc2 = c2; hco2 = co2;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic lit(input string name, input logic [31:0] av, input logic [31:0] bv,
                      input logic civ, input logic subv, input logic [31:0] ec,
                      input logic eco, input logic eovf, input logic ecp, input logic ecg);
      int lat;
      @(posedge clk); #1;
      a = av; b = bv; ci = civ; sub_v = subv; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'd4);
      chk({name, "_c"},   {32'd0, c1}, {32'd0, ec});
      chk({name, "_co"},  {63'd0, co1},  {63'd0, eco});
      chk({name, "_ovf"}, {63'd0, ovf1}, {63'd0, eovf});
      chk({name, "_cp"},  {63'd0, cp1},  {63'd0, ecp});
      chk({name, "_cg"},  {63'd0, cg1},  {63'd0, ecg});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d/%0d beats outstanding required 0",
                  name, exp_q1.size(), exp_q2.size());
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int r0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; ci = 1'b0; sub_v = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid1}, 64'd0);
      chk("rst_c",         {32'd0, c1}, 64'd0);
      chk("rst_flags",     {60'd0, co1, ovf1, cp1, cg1}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready1}, 64'd1);
      chk("rst_w13",       {50'd0, out_valid2, c2}, 64'd0);
      rst = 1'b0;

      // Hand-computed vectors pinning carry, overflow and group p/g.
      lit("all_ones_plus1", 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1);
      lit("pos_ovf",        32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("neg_ovf",        32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1);
      lit("ci_only",        32'h0,         32'h0,         1'b1, 1'b0, 32'h1,         1'b0, 1'b0, 1'b0, 1'b0);
      lit("ci_ripple",      32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0);
      lit("chunk_carry",    32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FPA_ADD_SUBTRACT_EN
      lit("sub_5_7",        32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      lit("sub_7_5",        32'd7,         32'd5,         1'b1, 1'b1, 32'd2,         1'b1, 1'b0, 1'b1, 1'b1);
`endif
      drain("lit");

      // Back-to-back stream: 100 beats must retire with no bubble.
      r0 = ret1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         a = 32'(i); b = 32'(2 * i); ci = 1'b0; sub_v = 1'b0; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("stream_throughput", 64'(ret1 - r0), 64'd100);
      drain("stream");

      // Random operands with 50% out_ready backpressure.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid || acc_seen) begin
            in_valid = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            ci = 1'($urandom_range(0, 1));
`ifdef FPA_ADD_SUBTRACT_EN
            sub_v = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
         end
      end
      @(posedge clk); #1;
      drain("random");

      // Reset with three beats in flight: nothing may emerge afterwards.
      sub_v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         a = 32'(100 + i); b = 32'(7 * i); ci = 1'b1; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {62'd0, out_valid1, out_valid2}, 64'd0);
      chk("midrst_c",         {32'd0, c1}, 64'd0);
      exp_q1.delete();
      exp_q2.delete();
      r0 = ret1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_stale", 64'(ret1 - r0), 64'd0);
      lit("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
      drain("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
